// File: rtl/quadrature_decoder_if.sv
// Signal bundle between the encoder front end / register bank (master) and the
// quadrature decoder (slave).
interface quadrature_decoder_if #(
  parameter int unsigned POS_WIDTH = 32
);
  logic                 quad_a;
  logic                 quad_b;
  logic                 quad_i;
  logic                 count_enable;
  logic                 pos_clear;
  logic                 err_clear;
  logic [POS_WIDTH-1:0] position;
  logic                 direction;
  logic                 step;
  logic                 quad_error;
  logic [POS_WIDTH-1:0] index_pos;
  logic                 index_seen;

  modport master (
    output quad_a, quad_b, quad_i, count_enable, pos_clear, err_clear,
    input  position, direction, step, quad_error, index_pos, index_seen
  );

  modport slave (
    input  quad_a, quad_b, quad_i, count_enable, pos_clear, err_clear,
    output position, direction, step, quad_error, index_pos, index_seen
  );
endinterface

// File: rtl/quadrature_decoder.sv
// Glitch-filtered x4 quadrature decoder with wrapping signed position, step/direction
// reporting, sticky illegal-transition flag and index position capture.
module quadrature_decoder #(
  parameter int unsigned POS_WIDTH     = 32,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input logic                  clk,
  input logic                  reset,
  quadrature_decoder_if.slave  bus
);

  localparam logic [7:0] FiltLast = 8'(FILTER_CYCLES - 1);

  // Channel order in the packed vectors: [0] = A, [1] = B, [2] = index.
  logic [2:0]      raw;
  logic [2:0]      filt_q, filt_d;
  logic [2:0][7:0] cnt_q, cnt_d;

  logic [1:0]           prev_ab_q;
  logic                 prev_i_q;
  logic [POS_WIDTH-1:0] position_q, position_d;
  logic                 direction_q, direction_d;
  logic                 step_q, step_d;
  logic                 quad_error_q, quad_error_d;
  logic [POS_WIDTH-1:0] index_pos_q, index_pos_d;
  logic                 index_seen_q, index_seen_d;

  logic [1:0] cur_ab;
  logic [1:0] delta;
  logic       fwd, rev, illegal, idx_rise;

  assign raw = {bus.quad_i, bus.quad_b, bus.quad_a};

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int ch = 0; ch < 3; ch++) begin
      if (raw[ch] != filt_q[ch]) begin
        if (cnt_q[ch] == FiltLast) begin
          filt_d[ch] = raw[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 8'd1;
        end
      end
    end
  end

  // Map Gray-coded {A,B} onto a 2-bit phase so forward steps are +1 mod 4.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    logic [1:0] p;
    unique case (ab)
      2'b00:   p = 2'd0;
      2'b10:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  assign cur_ab   = {filt_q[0], filt_q[1]};
  assign delta    = phase(cur_ab) - phase(prev_ab_q);
  assign fwd      = (delta == 2'd1);
  assign rev      = (delta == 2'd3);
  assign illegal  = (delta == 2'd2);
  assign idx_rise = filt_q[2] & ~prev_i_q;

  always_comb begin
    position_d   = position_q;
    direction_d  = direction_q;
    step_d       = 1'b0;
    quad_error_d = quad_error_q;
    index_pos_d  = index_pos_q;
    index_seen_d = index_seen_q;

    if (bus.count_enable && fwd) begin
      position_d  = position_q + POS_WIDTH'(1);
      direction_d = 1'b1;
      step_d      = 1'b1;
    end else if (bus.count_enable && rev) begin
      position_d  = position_q - POS_WIDTH'(1);
      direction_d = 1'b0;
      step_d      = 1'b1;
    end
    if (bus.pos_clear) begin
      position_d = '0;
    end

    // Clears first so a same-cycle event wins.
    if (bus.err_clear) begin
      quad_error_d = 1'b0;
      index_seen_d = 1'b0;
    end
    if (illegal) begin
      quad_error_d = 1'b1;
    end
    if (idx_rise) begin
      index_seen_d = 1'b1;
      index_pos_d  = position_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q       <= '0;
      cnt_q        <= '0;
      prev_ab_q    <= 2'b00;
      prev_i_q     <= 1'b0;
      position_q   <= '0;
      direction_q  <= 1'b0;
      step_q       <= 1'b0;
      quad_error_q <= 1'b0;
      index_pos_q  <= '0;
      index_seen_q <= 1'b0;
    end else begin
      filt_q       <= filt_d;
      cnt_q        <= cnt_d;
      prev_ab_q    <= cur_ab;
      prev_i_q     <= filt_q[2];
      position_q   <= position_d;
      direction_q  <= direction_d;
      step_q       <= step_d;
      quad_error_q <= quad_error_d;
      index_pos_q  <= index_pos_d;
      index_seen_q <= index_seen_d;
    end
  end

  assign bus.position   = position_q;
  assign bus.direction  = direction_q;
  assign bus.step       = step_q;
  assign bus.quad_error = quad_error_q;
  assign bus.index_pos  = index_pos_q;
  assign bus.index_seen = index_seen_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: a 32-bit instance plus a 3-bit instance
// sharing the same inputs, used to reach the positive wrap boundary quickly.
module tb_quadrature_decoder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   step_total = 0;
  logic cur_a = 1'b0;
  logic cur_b = 1'b0;

  quadrature_decoder_if #(.POS_WIDTH(32)) qif ();
  quadrature_decoder_if #(.POS_WIDTH(3))  sif ();

  quadrature_decoder #(.POS_WIDTH(32), .FILTER_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (qif.slave)
  );

  quadrature_decoder #(.POS_WIDTH(3), .FILTER_CYCLES(4)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  assign sif.quad_a       = qif.quad_a;
  assign sif.quad_b       = qif.quad_b;
  assign sif.quad_i       = qif.quad_i;
  assign sif.count_enable = qif.count_enable;
  assign sif.pos_clear    = qif.pos_clear;
  assign sif.err_clear    = qif.err_clear;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (qif.step === 1'b1) step_total++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] next_fwd(input logic [1:0] ab);
    logic [1:0] n;
    case (ab)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] next_rev(input logic [1:0] ab);
    logic [1:0] n;
    case (ab)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  // Apply one input state, watch 10 clocks; a counted step must pulse once, 5 clocks later.
  task automatic move(input logic a, input logic b, input logic i, input logic exp_step,
                      input string tag);
    int hits;
    int at;
    hits = 0;
    at   = 0;
    @(posedge clk); #1;
    qif.quad_a = a;
    qif.quad_b = b;
    qif.quad_i = i;
    cur_a = a;
    cur_b = b;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (qif.step === 1'b1) begin
        hits++;
        at = k;
      end
    end
    check_eq({tag, " step count"}, hits, exp_step ? 32'd1 : 32'd0);
    if (exp_step) check_eq({tag, " step latency"}, at, 32'd6);
  endtask

  task automatic fwd(input int n, input logic exp_step, input string tag);
    logic [1:0] nx;
    for (int k = 0; k < n; k++) begin
      nx = next_fwd({cur_a, cur_b});
      move(nx[1], nx[0], qif.quad_i, exp_step, tag);
    end
  endtask

  task automatic rev(input int n, input logic exp_step, input string tag);
    logic [1:0] nx;
    for (int k = 0; k < n; k++) begin
      nx = next_rev({cur_a, cur_b});
      move(nx[1], nx[0], qif.quad_i, exp_step, tag);
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    qif.pos_clear = 1'b1;
    @(posedge clk); #1;
    qif.pos_clear = 1'b0;
  endtask

  task automatic pulse_err_clear();
    @(posedge clk); #1;
    qif.err_clear = 1'b1;
    @(posedge clk); #1;
    qif.err_clear = 1'b0;
  endtask

  task automatic glitch_a(input int len);
    @(posedge clk); #1;
    qif.quad_a = 1'b1;
    repeat (len) @(posedge clk);
    #1;
    qif.quad_a = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [1:0] nx;
    qif.quad_a       = 1'b0;
    qif.quad_b       = 1'b0;
    qif.quad_i       = 1'b0;
    qif.count_enable = 1'b1;
    qif.pos_clear    = 1'b0;
    qif.err_clear    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset position", qif.position, 32'd0);
    check_eq("reset direction", 32'(qif.direction), 32'd0);
    check_eq("reset step", 32'(qif.step), 32'd0);
    check_eq("reset quad_error", 32'(qif.quad_error), 32'd0);
    check_eq("reset index_pos", qif.index_pos, 32'd0);
    check_eq("reset index_seen", 32'(qif.index_seen), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 8 full forward cycles
    fwd(32, 1'b1, "fwd");
    check_eq("fwd position", qif.position, 32'd32);
    check_eq("fwd direction", 32'(qif.direction), 32'd1);
    check_eq("fwd step total", step_total, 32'd32);
    check_eq("fwd small position", 32'(sif.position), 32'd0);

    pulse_clear();
    check_eq("clear position", qif.position, 32'd0);

    // Reverse from zero: first step wraps to all ones
    rev(1, 1'b1, "rev");
    check_eq("rev wrap position", qif.position, 32'hFFFF_FFFF);
    check_eq("rev wrap small", 32'(sif.position), 32'd7);
    rev(31, 1'b1, "rev");
    check_eq("rev position", qif.position, 32'hFFFF_FFE0);
    check_eq("rev direction", 32'(qif.direction), 32'd0);

    // Glitch filter
    base = step_total;
    glitch_a(3);
    check_eq("glitch3 steps", step_total - base, 32'd0);
    check_eq("glitch3 position", qif.position, 32'hFFFF_FFE0);
    base = step_total;
    glitch_a(4);
    check_eq("pulse4 steps", step_total - base, 32'd2);
    check_eq("pulse4 position", qif.position, 32'hFFFF_FFE0);
    check_eq("pulse4 direction", 32'(qif.direction), 32'd0);

    // Illegal transition 00 -> 11
    move(1'b1, 1'b1, 1'b0, 1'b0, "illegal");
    check_eq("illegal quad_error", 32'(qif.quad_error), 32'd1);
    check_eq("illegal position", qif.position, 32'hFFFF_FFE0);
    pulse_err_clear();
    check_eq("err_clear quad_error", 32'(qif.quad_error), 32'd0);

    // err_clear in the same cycle as an illegal transition 11 -> 00
    @(posedge clk); #1;
    qif.quad_a = 1'b0;
    qif.quad_b = 1'b0;
    cur_a = 1'b0;
    cur_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    qif.err_clear = 1'b1;
    @(posedge clk); #1;
    qif.err_clear = 1'b0;
    @(negedge clk);
    check_eq("set wins quad_error", 32'(qif.quad_error), 32'd1);
    repeat (8) @(posedge clk);

    // Positive wrap on the 3-bit instance: 3 -> -4
    pulse_clear();
    fwd(3, 1'b1, "wrap");
    check_eq("small max", 32'(sif.position), 32'd3);
    fwd(1, 1'b1, "wrap");
    check_eq("small wrap", 32'(sif.position), 32'd4);
    check_eq("big after wrap", qif.position, 32'd4);

    // pos_clear together with a reverse step 00 -> 01
    @(posedge clk); #1;
    qif.quad_b = 1'b1;
    cur_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    qif.pos_clear = 1'b1;
    @(posedge clk); #1;
    qif.pos_clear = 1'b0;
    @(negedge clk);
    check_eq("clear+step step", 32'(qif.step), 32'd1);
    check_eq("clear+step position", qif.position, 32'd0);
    check_eq("clear+step direction", 32'(qif.direction), 32'd0);
    repeat (6) @(posedge clk);

    // Index edge coinciding with the step from 17 to 18
    fwd(17, 1'b1, "to17");
    check_eq("pos 17", qif.position, 32'd17);
    nx = next_fwd({cur_a, cur_b});
    move(nx[1], nx[0], 1'b1, 1'b1, "index");
    check_eq("index_pos", qif.index_pos, 32'd17);
    check_eq("index_seen", 32'(qif.index_seen), 32'd1);
    check_eq("index position", qif.position, 32'd18);
    pulse_err_clear();
    check_eq("err_clear index_seen", 32'(qif.index_seen), 32'd0);
    check_eq("err_clear keeps index_pos", qif.index_pos, 32'd17);

    // count_enable low: frozen position, illegal still flagged
    qif.count_enable = 1'b0;
    fwd(4, 1'b0, "disabled");
    check_eq("disabled position", qif.position, 32'd18);
    move(~cur_a, ~cur_b, 1'b1, 1'b0, "disabled illegal");
    check_eq("disabled quad_error", 32'(qif.quad_error), 32'd1);
    qif.count_enable = 1'b1;
    check_eq("pre-reset direction", 32'(qif.direction), 32'd1);

    // Asynchronous reset in the middle of a movement
    @(posedge clk); #1;
    nx = next_fwd({cur_a, cur_b});
    qif.quad_a = nx[1];
    qif.quad_b = nx[0];
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("midreset position", qif.position, 32'd0);
    check_eq("midreset direction", 32'(qif.direction), 32'd0);
    check_eq("midreset quad_error", 32'(qif.quad_error), 32'd0);
    check_eq("midreset index_pos", qif.index_pos, 32'd0);
    check_eq("midreset index_seen", 32'(qif.index_seen), 32'd0);
    qif.quad_a = 1'b0;
    qif.quad_b = 1'b0;
    qif.quad_i = 1'b0;
    cur_a = 1'b0;
    cur_b = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    base = step_total;
    repeat (12) @(posedge clk);
    #1;
    check_eq("post-reset steps", step_total - base, 32'd0);
    check_eq("post-reset position", qif.position, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
